// File: rtl/nibble_serial_comparator.sv
// Serial magnitude comparator: one 4-bit nibble per clock, LSB nibble first, via a G/L/E cascade.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+N (N = WIDTH/4).
// Backpressure: none; start is taken only in IDLE, and a start while busy is dropped without queueing.
//
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst_n  - synchronous active-low reset; wins over everything, including a compare in flight
//   start  - compare request, accepted only while idle
//   a, b   - WIDTH-bit unsigned operands, captured on the accepting edge only
//   busy   - high while running and during the done cycle
//   done   - one-cycle pulse; gt/lt/eq carry the new result from this cycle on
//   gt/lt/eq - registered result; holds until the next done
module nibble_serial_comparator #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int N    = WIDTH / 4;
    localparam int IDXW = $clog2(N);
    localparam logic [IDXW-1:0] LASTIDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] shadowA;
    logic [WIDTH-1:0] shadowB;
    logic             casG;
    logic             casL;
    logic             casE;

    logic [3:0] nibA;
    logic [3:0] nibB;
    logic       nextG;
    logic       nextL;
    logic       nextE;

    // The shadow registers shift right each RUN cycle, so the nibble under
    // comparison is always in the low 4 bits; idx only counts nibbles.
    always_comb begin
        nibA  = shadowA[3:0];
        nibB  = shadowB[3:0];
        nextG = (nibA > nibB) | ((nibA == nibB) & casG);
        nextL = (nibA < nibB) | ((nibA == nibB) & casL);
        nextE = (nibA == nibB) & casE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= StIdle;
            idx     <= '0;
            shadowA <= '0;
            shadowB <= '0;
            casG    <= 1'b0;
            casL    <= 1'b0;
            casE    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        shadowA <= a;
                        shadowB <= b;
                        idx     <= '0;
                        casG    <= 1'b0;
                        casL    <= 1'b0;
                        casE    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    casG    <= nextG;
                    casL    <= nextL;
                    casE    <= nextE;
                    shadowA <= shadowA >> 4;
                    shadowB <= shadowB >> 4;
                    if (idx == LASTIDX) begin
                        // Final nibble: publish the cascade straight to the
                        // outputs so they never show partial values.
                        gt    <= nextG;
                        lt    <= nextL;
                        eq    <= nextE;
                        done  <= 1'b1;
                        idx   <= '0;
                        state <= StDone;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Bench for nibble_serial_comparator (WIDTH=16): directed cases plus random operands
// checked against plain unsigned arithmetic; timing checked cycle by cycle.
module tb_nibble_serial_comparator;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    int passed = 0;
    int total  = 0;

    // Last published result, as the outputs should be holding it.
    logic prevG = 1'b0;
    logic prevL = 1'b0;
    logic prevE = 1'b0;

    nibble_serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .gt   (gt),
        .lt   (lt),
        .eq   (eq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chkHeld(input string tag);
        chk({tag, ".gt"}, {31'b0, gt}, {31'b0, prevG});
        chk({tag, ".lt"}, {31'b0, lt}, {31'b0, prevL});
        chk({tag, ".eq"}, {31'b0, eq}, {31'b0, prevE});
    endtask

    // Full compare from IDLE: accept, N run cycles, done cycle, back to idle.
    // Operands are scrambled right after acceptance to show they are not re-sampled.
    task automatic doCompare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
        logic eG, eL, eE;
        eG = (av > bv);
        eL = (av < bv);
        eE = (av == bv);
        start = 1'b1;
        a = av;
        b = bv;
        tick();
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        chk({tag, ".busy0"}, {31'b0, busy}, 32'd1);
        chk({tag, ".done0"}, {31'b0, done}, 32'd0);
        chkHeld({tag, ".run"});
        for (int i = 1; i < N; i++) begin
            tick();
            chk({tag, ".busyRun"}, {31'b0, busy}, 32'd1);
            chk({tag, ".doneRun"}, {31'b0, done}, 32'd0);
            chkHeld({tag, ".run"});
        end
        tick();
        chk({tag, ".done"}, {31'b0, done}, 32'd1);
        chk({tag, ".busyDone"}, {31'b0, busy}, 32'd1);
        chk({tag, ".gt"}, {31'b0, gt}, {31'b0, eG});
        chk({tag, ".lt"}, {31'b0, lt}, {31'b0, eL});
        chk({tag, ".eq"}, {31'b0, eq}, {31'b0, eE});
        chk({tag, ".onehot"}, $countones({gt, lt, eq}), 32'd1);
        prevG = eG;
        prevL = eL;
        prevE = eE;
        tick();
        chk({tag, ".doneOff"}, {31'b0, done}, 32'd0);
        chk({tag, ".busyOff"}, {31'b0, busy}, 32'd0);
        chkHeld({tag, ".idle"});
    endtask

    initial begin
        int doneCount;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        // 1: reset held 2 clocks with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        a = 16'h1234;
        b = 16'h0001;
        tick();
        tick();
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.gt", {31'b0, gt}, 32'd0);
        chk("rst.lt", {31'b0, lt}, 32'd0);
        chk("rst.eq", {31'b0, eq}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst.noStart", {31'b0, busy}, 32'd0);

        // 2..4: directed operands
        doCompare(16'h1234, 16'h1234, "equal");
        doCompare(16'h8000, 16'h7FFF, "msbOverride");
        doCompare(16'h0001, 16'h0002, "lsbPropagate");

        // 5: start pulsed mid-run is ignored; only one done
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'h0000;
        tick();
        start = 1'b0;
        doneCount = 0;
        tick();
        doneCount += int'(done);
        start = 1'b1;
        a = 16'h0000;
        b = 16'hFFFF;
        tick();
        doneCount += int'(done);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            doneCount += int'(done);
            if (done) begin
                chk("ignored.gt", {31'b0, gt}, 32'd1);
                chk("ignored.lt", {31'b0, lt}, 32'd0);
                chk("ignored.eq", {31'b0, eq}, 32'd0);
            end
        end
        chk("ignored.doneCount", doneCount, 32'd1);
        chk("ignored.idle", {31'b0, busy}, 32'd0);
        prevG = 1'b1;
        prevL = 1'b0;
        prevE = 1'b0;

        // 6: reset during RUN cycle 2 discards the compare
        start = 1'b1;
        a = 16'h0005;
        b = 16'h0009;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midRst.busy", {31'b0, busy}, 32'd0);
        chk("midRst.done", {31'b0, done}, 32'd0);
        chk("midRst.gt", {31'b0, gt}, 32'd0);
        chk("midRst.lt", {31'b0, lt}, 32'd0);
        chk("midRst.eq", {31'b0, eq}, 32'd0);
        prevG = 1'b0;
        prevL = 1'b0;
        prevE = 1'b0;
        doneCount = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            doneCount += int'(done);
        end
        chk("midRst.noDone", doneCount, 32'd0);
        doCompare(16'h00FF, 16'h00FE, "afterRst");

        // start held high: re-triggers every N+2 cycles
        start = 1'b1;
        a = 16'h4321;
        b = 16'h4322;
        tick();
        doneCount = 0;
        for (int i = 1; i <= 3 * (N + 2); i++) begin
            tick();
            doneCount += int'(done);
            if (done) chk("held.lt", {31'b0, lt}, 32'd1);
        end
        chk("held.doneCount", doneCount, 32'd3);
        start = 1'b0;
        for (int i = 0; i < N + 2; i++) tick();
        chk("held.idle", {31'b0, busy}, 32'd0);
        prevG = 1'b0;
        prevL = 1'b1;
        prevE = 1'b0;

        // Random operands; some share upper nibbles or are equal outright
        for (int t = 0; t < 24; t++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case (t % 4)
                1: rb = ra;
                2: rb = {ra[WIDTH-1:4], rb[3:0]};
                3: rb = {ra[WIDTH-1:8], rb[7:0]};
                default: ;
            endcase
            doCompare(ra, rb, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
